inst_encoder: RTL

Pipelined RISC-V instruction encoder: accepts decoded fields (opcode, registers, functs, 32-bit immediate, format select) and packs them into a 32-bit instruction word. It is the inverse of the pipeline's immediate generator and uses the same format-select encoding. It sits on the program-load/self-test path, emitting packed words with sequential instruction-memory word addresses over a valid/ready stream. Immediates that do not fit the selected format are flagged and replaced by a NOP.

---
 rtl/riscv_enc_pkg.sv | 21 ++
 rtl/imm_range_chk.sv | 64 ++++++
 rtl/inst_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared encodings for the instruction encoder and the pipeline's immediate generator.
package riscv_enc_pkg;

  localparam logic [2:0] IMMSEL_I = 3'b000;
  localparam logic [2:0] IMMSEL_S = 3'b001;
  localparam logic [2:0] IMMSEL_B = 3'b010;
  localparam logic [2:0] IMMSEL_U = 3'b011;
  localparam logic [2:0] IMMSEL_J = 3'b100;
  localparam logic [2:0] IMMSEL_R = 3'b101;

  // addi x0, x0, 0 -- emitted in place of any word that cannot be encoded
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_code_e;

endpackage

// File: rtl/imm_range_chk.sv
// Decides whether an immediate can be represented in the selected format.
// Illegal format wins over misalignment, which wins over range overflow.
module imm_range_chk
  import riscv_enc_pkg::*;
#(
  parameter int WID_DATA = 32
) (
  input  logic [WID_DATA-1:0] imm,
  input  logic [2:0]          immsel,
  input  logic [6:0]          opcode,
  output logic [1:0]          err_code
);

  logic fits_12;
  logic fits_13;
  logic fits_21;
  logic low_zero;
  logic illegal;
  logic misalign;
  logic range_bad;
  logic unused_opcode;

  assign unused_opcode = ^{opcode[6:4], opcode[2:0]};

  // Sign-extension tests: the bits above the field must all copy the field's top bit
  always_comb begin
    fits_12  = (imm[WID_DATA-1:11] == '0) || (imm[WID_DATA-1:11] == '1);
    fits_13  = (imm[WID_DATA-1:12] == '0) || (imm[WID_DATA-1:12] == '1);
    fits_21  = (imm[WID_DATA-1:20] == '0) || (imm[WID_DATA-1:20] == '1);
    low_zero = (imm[11:0] == 12'd0);
  end

  // Classify the immediate; a J word whose opcode bit 3 is clear would be read back as I-type
  always_comb begin
    illegal   = 1'b0;
    misalign  = 1'b0;
    range_bad = 1'b0;
    case (immsel)
      IMMSEL_I, IMMSEL_S: range_bad = !fits_12;
      IMMSEL_B: begin
        misalign  = imm[0];
        range_bad = !fits_13;
      end
      IMMSEL_U: range_bad = !low_zero;
      IMMSEL_J: begin
        illegal   = !opcode[3];
        misalign  = imm[0];
        range_bad = !fits_21;
      end
      IMMSEL_R: ;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      err_code = ERR_ILLEGAL;
    end else if (misalign) begin
      err_code = ERR_MISALIGN;
    end else if (range_bad) begin
      err_code = ERR_RANGE;
    end else begin
      err_code = ERR_OK;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage instruction encoder: S1 holds the decoded fields and produces the packed
// word, S2 is the output register carrying the word with its instruction-memory address.
// Addresses are handed out when a word enters S2, so an address clear re-addresses
// anything still waiting in S1 while the word already in S2 keeps its number.
module inst_encoder
  import riscv_enc_pkg::*;
#(
  parameter int                  WID_DATA  = 32,
  parameter int                  WID_ADDR  = 10,
  parameter logic [WID_ADDR-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          immsel,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [WID_DATA-1:0] imm,
  input  logic                addr_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WID_DATA-1:0] inst,
  output logic [WID_ADDR-1:0] addr,
  output logic                err,
  output logic [1:0]          err_code,
  output logic                err_sticky
);

  logic                s1_v;
  logic [2:0]          s1_immsel;
  logic [6:0]          s1_opcode;
  logic [4:0]          s1_rd;
  logic [4:0]          s1_rs1;
  logic [4:0]          s1_rs2;
  logic [2:0]          s1_funct3;
  logic [6:0]          s1_funct7;
  logic [WID_DATA-1:0] s1_imm;
  logic [1:0]          s1_code;
  logic [WID_DATA-1:0] s1_packed;
  logic [WID_ADDR-1:0] next_addr;
  logic [WID_ADDR-1:0] load_addr;
  logic                accept;
  logic                s2_load;
  logic                out_fire;

  assign in_ready  = rst_n && (!s1_v || !out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign s2_load   = s1_v && (!out_valid || out_ready);
  assign out_fire  = out_valid && out_ready;
  assign load_addr = addr_clr ? BASE_ADDR : next_addr;

  imm_range_chk #(
    .WID_DATA (WID_DATA)
  ) u_range_chk (
    .imm      (s1_imm),
    .immsel   (s1_immsel),
    .opcode   (s1_opcode),
    .err_code (s1_code)
  );

  // S1 occupancy: filled on accept, emptied when its word moves to S2 with nothing behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
    end else if (accept) begin
      s1_v <= 1'b1;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  // S1 field capture; contents are meaningless while s1_v is low
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_immsel <= immsel;
      s1_opcode <= opcode;
      s1_rd     <= rd;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_funct3 <= funct3;
      s1_funct7 <= funct7;
      s1_imm    <= imm;
    end
  end

  // Pack the S1 fields into the selected format, or substitute a NOP when the check fails
  always_comb begin
    s1_packed = NOP_INST;
    case (s1_immsel)
      IMMSEL_I: s1_packed = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      IMMSEL_S: s1_packed = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      IMMSEL_B: s1_packed = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:1], s1_imm[11], s1_opcode};
      IMMSEL_U: s1_packed = {s1_imm[31:12], s1_rd, s1_opcode};
      IMMSEL_J: s1_packed = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                             s1_rd, s1_opcode};
      IMMSEL_R: s1_packed = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      default:  s1_packed = NOP_INST;
    endcase
    if (s1_code != ERR_OK) begin
      s1_packed = NOP_INST;
    end
  end

  // S2 output register, address counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      inst       <= '0;
      addr       <= BASE_ADDR;
      err        <= 1'b0;
      err_code   <= ERR_OK;
      err_sticky <= 1'b0;
      next_addr  <= BASE_ADDR;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        inst      <= s1_packed;
        addr      <= load_addr;
        err       <= (s1_code != ERR_OK);
        err_code  <= s1_code;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      next_addr  <= s2_load ? load_addr + WID_ADDR'(1) : load_addr;
      err_sticky <= (err_sticky && !addr_clr) || (s2_load && (s1_code != ERR_OK));
    end
  end

endmodule
